// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM Wishbone arbiter.
package sram_arb_pkg;

  localparam int ARB_AW = 8;
  localparam int ARB_DW = 32;

  localparam logic GNT_IB = 1'b0;
  localparam logic GNT_DB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2,
    ACK  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/sram_rr_arb2.sv
// Combinational two-way round-robin pick: req[0]=ibus, req[1]=dbus.
module sram_rr_arb2
  import sram_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_gnt_valid,
  output logic       o_gnt_id
);

  // Single requester wins outright; on collision the port that did not win last time goes.
  always_comb begin
    o_gnt_valid = 1'b0;
    o_gnt_id    = GNT_IB;
    case (i_req)
      2'b01: begin
        o_gnt_valid = 1'b1;
        o_gnt_id    = GNT_IB;
      end
      2'b10: begin
        o_gnt_valid = 1'b1;
        o_gnt_id    = GNT_DB;
      end
      2'b11: begin
        o_gnt_valid = 1'b1;
        o_gnt_id    = ~i_last_grant;
      end
      default: begin
        o_gnt_valid = 1'b0;
        o_gnt_id    = GNT_IB;
      end
    endcase
  end

endmodule

// File: rtl/sram_wb_arbiter.sv
// Shares the SRAM macro RW port between the CPU ibus (read-only) and dbus.
// One access takes IDLE->CMD->WAIT->ACK; macro controls are fully registered
// and read data is captured at the posedge ending WAIT.
module sram_wb_arbiter
  import sram_arb_pkg::*;
#(
  parameter int AW = ARB_AW,
  parameter int DW = ARB_DW
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [31:0]     i_ib_adr,
  input  logic            i_ib_stb,
  output logic [DW-1:0]   o_ib_rdt,
  output logic            o_ib_ack,
  input  logic [31:0]     i_db_adr,
  input  logic [DW-1:0]   i_db_dat,
  input  logic [DW/8-1:0] i_db_sel,
  input  logic            i_db_we,
  input  logic            i_db_stb,
  output logic [DW-1:0]   o_db_rdt,
  output logic            o_db_ack,
  output logic            o_sram_csb,
  output logic            o_sram_web,
  output logic [DW/8-1:0] o_sram_wmask,
  output logic [AW-1:0]   o_sram_addr,
  output logic [DW-1:0]   o_sram_din,
  input  logic [DW-1:0]   i_sram_dout
);

  arb_state_e      r_state,  w_state_nxt;
  logic            r_last_grant, w_last_grant_nxt;
  logic            r_gnt,    w_gnt_nxt;
  logic            r_csb,    w_csb_nxt;
  logic            r_web,    w_web_nxt;
  logic [DW/8-1:0] r_wmask,  w_wmask_nxt;
  logic [AW-1:0]   r_addr,   w_addr_nxt;
  logic [DW-1:0]   r_din,    w_din_nxt;
  logic            r_ib_ack, w_ib_ack_nxt;
  logic            r_db_ack, w_db_ack_nxt;
  logic [DW-1:0]   r_ib_rdt, w_ib_rdt_nxt;
  logic [DW-1:0]   r_db_rdt, w_db_rdt_nxt;

  logic w_gnt_valid;
  logic w_gnt_id;
  logic w_unused_adr;

  // Address bits outside the word index alias onto the same RAM word.
  assign w_unused_adr = ^{i_ib_adr[31:AW+2], i_ib_adr[1:0], i_db_adr[31:AW+2], i_db_adr[1:0]};

  sram_rr_arb2 u_rr_arb (
    .i_req        ({i_db_stb, i_ib_stb}),
    .i_last_grant (r_last_grant),
    .o_gnt_valid  (w_gnt_valid),
    .o_gnt_id     (w_gnt_id)
  );

  // Next-state and next-register values; requests are only looked at in IDLE.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_gnt_nxt        = r_gnt;
    w_csb_nxt        = r_csb;
    w_web_nxt        = r_web;
    w_wmask_nxt      = r_wmask;
    w_addr_nxt       = r_addr;
    w_din_nxt        = r_din;
    w_ib_ack_nxt     = 1'b0;
    w_db_ack_nxt     = 1'b0;
    w_ib_rdt_nxt     = r_ib_rdt;
    w_db_rdt_nxt     = r_db_rdt;
    case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_state_nxt      = CMD;
          w_csb_nxt        = 1'b0;
          w_gnt_nxt        = w_gnt_id;
          w_last_grant_nxt = w_gnt_id;
          if (w_gnt_id == GNT_DB) begin
            w_addr_nxt  = i_db_adr[AW+1:2];
            w_web_nxt   = ~i_db_we;
            w_wmask_nxt = i_db_sel;
            w_din_nxt   = i_db_dat;
          end else begin
            w_addr_nxt  = i_ib_adr[AW+1:2];
            w_web_nxt   = 1'b1;
            w_wmask_nxt = {(DW/8){1'b0}};
            w_din_nxt   = {DW{1'b0}};
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CMD: begin
        // Macro has captured the controls at this edge; release chip select.
        w_csb_nxt   = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        // Macro drove dout on the negedge; take it before it goes invalid.
        if (r_gnt == GNT_DB) begin
          w_db_rdt_nxt = i_sram_dout;
          w_db_ack_nxt = 1'b1;
        end else begin
          w_ib_rdt_nxt = i_sram_dout;
          w_ib_ack_nxt = 1'b1;
        end
        w_state_nxt = ACK;
      end
      ACK: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_csb_nxt   = 1'b1;
      end
    endcase
  end

  // State, grant, macro controls and return path, with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= GNT_IB;
      r_gnt        <= GNT_IB;
      r_csb        <= 1'b1;
      r_web        <= 1'b1;
      r_wmask      <= {(DW/8){1'b0}};
      r_addr       <= {AW{1'b0}};
      r_din        <= {DW{1'b0}};
      r_ib_ack     <= 1'b0;
      r_db_ack     <= 1'b0;
      r_ib_rdt     <= {DW{1'b0}};
      r_db_rdt     <= {DW{1'b0}};
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_gnt        <= w_gnt_nxt;
      r_csb        <= w_csb_nxt;
      r_web        <= w_web_nxt;
      r_wmask      <= w_wmask_nxt;
      r_addr       <= w_addr_nxt;
      r_din        <= w_din_nxt;
      r_ib_ack     <= w_ib_ack_nxt;
      r_db_ack     <= w_db_ack_nxt;
      r_ib_rdt     <= w_ib_rdt_nxt;
      r_db_rdt     <= w_db_rdt_nxt;
    end
  end

  assign o_sram_csb   = r_csb;
  assign o_sram_web   = r_web;
  assign o_sram_wmask = r_wmask;
  assign o_sram_addr  = r_addr;
  assign o_sram_din   = r_din;
  assign o_ib_ack     = r_ib_ack;
  assign o_db_ack     = r_db_ack;
  assign o_ib_rdt     = r_ib_rdt;
  assign o_db_rdt     = r_db_rdt;

endmodule

// File: tb/tb_sram_wb_arbiter.sv
// Scoreboard bench for sram_wb_arbiter with a behavioural model of the SRAM macro.
module tb_sram_wb_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam logic P_IB = 1'b0;
  localparam logic P_DB = 1'b1;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [31:0]   i_ib_adr;
  logic          i_ib_stb;
  logic [DW-1:0] o_ib_rdt;
  logic          o_ib_ack;
  logic [31:0]   i_db_adr;
  logic [DW-1:0] i_db_dat;
  logic [3:0]    i_db_sel;
  logic          i_db_we;
  logic          i_db_stb;
  logic [DW-1:0] o_db_rdt;
  logic          o_db_ack;
  logic          o_sram_csb;
  logic          o_sram_web;
  logic [3:0]    o_sram_wmask;
  logic [AW-1:0] o_sram_addr;
  logic [DW-1:0] o_sram_din;
  logic [DW-1:0] sram_dout;

  always #5 i_clk = ~i_clk;

  sram_wb_arbiter #(.AW(AW), .DW(DW)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_ib_adr     (i_ib_adr),
    .i_ib_stb     (i_ib_stb),
    .o_ib_rdt     (o_ib_rdt),
    .o_ib_ack     (o_ib_ack),
    .i_db_adr     (i_db_adr),
    .i_db_dat     (i_db_dat),
    .i_db_sel     (i_db_sel),
    .i_db_we      (i_db_we),
    .i_db_stb     (i_db_stb),
    .o_db_rdt     (o_db_rdt),
    .o_db_ack     (o_db_ack),
    .o_sram_csb   (o_sram_csb),
    .o_sram_web   (o_sram_web),
    .o_sram_wmask (o_sram_wmask),
    .o_sram_addr  (o_sram_addr),
    .o_sram_din   (o_sram_din),
    .i_sram_dout  (sram_dout)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Cycle counter used for latency expectations.
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic        port;
    logic        chk_dat;
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl_mem [0:255];

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {b, ~b, b ^ 8'h5A, 8'hC3};
  endfunction

  function automatic void push_exp(input logic port, input logic [31:0] adr,
                                   input logic chk_dat, input int c);
    exp_t e;
    e.port    = port;
    e.chk_dat = chk_dat;
    e.dat     = mdl_mem[adr[9:2]];
    e.cyc     = c;
    exp_q.push_back(e);
  endfunction

  function automatic void mdl_write(input logic [31:0] adr, input logic [31:0] dat,
                                    input logic [3:0] sel);
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) mdl_mem[adr[9:2]][8*b +: 8] = dat[8*b +: 8];
    end
  endfunction

  // SRAM macro model: registered inputs at posedge, access at negedge, dout garbage after posedge.
  logic [31:0] sram_mem [0:255];
  logic        m_csb, m_web;
  logic [3:0]  m_wmask;
  logic [7:0]  m_addr;
  logic [31:0] m_din;
  initial begin
    for (int i = 0; i < 256; i++) sram_mem[i] = pat(i);
    m_csb     = 1'b1;
    m_web     = 1'b1;
    m_wmask   = 4'h0;
    m_addr    = 8'h00;
    m_din     = 32'h0;
    sram_dout = 32'h0;
    forever begin
      @(posedge i_clk or negedge i_clk);
      if (i_clk) begin
        m_csb   = o_sram_csb;
        m_web   = o_sram_web;
        m_wmask = o_sram_wmask;
        m_addr  = o_sram_addr;
        m_din   = o_sram_din;
        sram_dout <= 32'hBAD0_BAD0;
      end else if (m_csb === 1'b0) begin
        if (!m_web) begin
          for (int b = 0; b < 4; b++) begin
            if (m_wmask[b]) sram_mem[m_addr][8*b +: 8] = m_din[8*b +: 8];
          end
        end else begin
          sram_dout <= sram_mem[m_addr];
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every ack, checks csb spacing.
  logic       mon_en = 1'b0;
  logic       prev_csb = 1'b1;
  int         csb_cnt = 0;
  logic [7:0] csb_addr;
  logic       csb_web;
  logic [3:0] csb_wmask;
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (mon_en) begin
        chk("csb_consec", {31'd0, (!prev_csb && !o_sram_csb)}, 32'd0);
        chk("dual_ack", {31'd0, (o_ib_ack && o_db_ack)}, 32'd0);
        if (!o_sram_csb) begin
          csb_cnt++;
          csb_addr  = o_sram_addr;
          csb_web   = o_sram_web;
          csb_wmask = o_sram_wmask;
        end
        prev_csb = o_sram_csb;
        if (o_ib_ack || o_db_ack) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_ack", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            chk("ack_port", {31'd0, o_db_ack}, {31'd0, e.port});
            chk("ack_cycle", 32'(cyc), 32'(e.cyc));
            if (e.chk_dat) chk("rdt", o_db_ack ? o_db_rdt : o_ib_rdt, e.dat);
          end
        end
      end
    end
  end

  task automatic sync();
    @(posedge i_clk);
    #1;
  endtask

  task automatic ib_xfer(input logic [31:0] base, input int n);
    for (int j = 0; j < n; j++) begin
      int t;
      i_ib_adr = base + 32'(4 * j);
      i_ib_stb = 1'b1;
      t = 0;
      @(negedge i_clk);
      while (!o_ib_ack && t < 50) begin
        @(negedge i_clk);
        t++;
      end
      chk("ib_ack_seen", {31'd0, o_ib_ack}, 32'd1);
    end
    i_ib_stb = 1'b0;
  endtask

  task automatic db_xfer(input logic [31:0] base, input logic [31:0] dat,
                         input logic [3:0] sel, input logic we, input int n);
    for (int j = 0; j < n; j++) begin
      int t;
      i_db_adr = base + 32'(4 * j);
      i_db_dat = dat;
      i_db_sel = sel;
      i_db_we  = we;
      i_db_stb = 1'b1;
      t = 0;
      @(negedge i_clk);
      while (!o_db_ack && t < 50) begin
        @(negedge i_clk);
        t++;
      end
      chk("db_ack_seen", {31'd0, o_db_ack}, 32'd1);
    end
    i_db_stb = 1'b0;
    i_db_we  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int c0;
    for (int i = 0; i < 256; i++) mdl_mem[i] = pat(i);

    // Reset with both requests pending.
    i_rst_n  = 1'b0;
    i_ib_adr = 32'h08;
    i_ib_stb = 1'b1;
    i_db_adr = 32'h0C;
    i_db_dat = 32'h0;
    i_db_sel = 4'hF;
    i_db_we  = 1'b0;
    i_db_stb = 1'b1;
    sync();
    mon_en = 1'b1;
    sync();
    sync();
    chk("rst_csb", {31'd0, o_sram_csb}, 32'd1);
    chk("rst_web", {31'd0, o_sram_web}, 32'd1);
    chk("rst_wmask", {28'd0, o_sram_wmask}, 32'd0);
    chk("rst_addr", {24'd0, o_sram_addr}, 32'd0);
    chk("rst_din", o_sram_din, 32'd0);
    chk("rst_acks", {30'd0, o_ib_ack, o_db_ack}, 32'd0);
    chk("rst_ib_rdt", o_ib_rdt, 32'd0);
    chk("rst_db_rdt", o_db_rdt, 32'd0);
    i_rst_n = 1'b1;
    c = cyc;
    push_exp(P_DB, 32'h0C, 1'b1, c + 3);
    push_exp(P_IB, 32'h08, 1'b1, c + 7);
    fork
      ib_xfer(32'h08, 1);
      db_xfer(32'h0C, 32'h0, 4'hF, 1'b0, 1);
    join

    // dbus full write, then read back.
    sync();
    c = cyc;
    c0 = csb_cnt;
    push_exp(P_DB, 32'h10, 1'b0, c + 3);
    mdl_write(32'h10, 32'hDEADBEEF, 4'hF);
    db_xfer(32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1);
    chk("wr_csb_cycles", 32'(csb_cnt - c0), 32'd1);
    chk("wr_addr", {24'd0, csb_addr}, 32'd4);
    chk("wr_web", {31'd0, csb_web}, 32'd0);
    chk("wr_wmask", {28'd0, csb_wmask}, 32'hF);
    sync();
    c = cyc;
    push_exp(P_DB, 32'h10, 1'b1, c + 3);
    db_xfer(32'h10, 32'h0, 4'hF, 1'b0, 1);
    sync();
    chk("db_rdt_hold", o_db_rdt, 32'hDEADBEEF);

    // Byte-masked write, then read.
    c = cyc;
    push_exp(P_DB, 32'h10, 1'b0, c + 3);
    mdl_write(32'h10, 32'h11223344, 4'h5);
    db_xfer(32'h10, 32'h11223344, 4'h5, 1'b1, 1);
    sync();
    c = cyc;
    push_exp(P_DB, 32'h10, 1'b1, c + 3);
    db_xfer(32'h10, 32'h0, 4'hF, 1'b0, 1);

    // Write with no byte selects still acks and leaves memory unchanged.
    sync();
    c = cyc;
    push_exp(P_DB, 32'h10, 1'b0, c + 3);
    mdl_write(32'h10, 32'h0, 4'h0);
    db_xfer(32'h10, 32'h0, 4'h0, 1'b1, 1);

    // ibus read of the masked word.
    sync();
    c = cyc;
    push_exp(P_IB, 32'h10, 1'b1, c + 3);
    ib_xfer(32'h10, 1);

    // Collision: last grant was ibus, so dbus goes first.
    sync();
    c = cyc;
    push_exp(P_DB, 32'h14, 1'b1, c + 3);
    push_exp(P_IB, 32'h10, 1'b1, c + 7);
    fork
      ib_xfer(32'h10, 1);
      db_xfer(32'h14, 32'h0, 4'hF, 1'b0, 1);
    join

    // Fairness: both ports stream four reads each; grants alternate starting with dbus.
    sync();
    c = cyc;
    for (int t = 0; t < 8; t++) begin
      if (t % 2 == 0) push_exp(P_DB, 32'h80 + 32'(4 * (t / 2)), 1'b1, c + 3 + 4 * t);
      else            push_exp(P_IB, 32'h40 + 32'(4 * (t / 2)), 1'b1, c + 3 + 4 * t);
    end
    fork
      ib_xfer(32'h40, 4);
      db_xfer(32'h80, 32'h0, 4'hF, 1'b0, 4);
    join

    // Reset asserted during WAIT: no ack, then a reissued aliased read completes.
    sync();
    i_ib_adr = 32'h20;
    i_ib_stb = 1'b1;
    sync();
    sync();
    i_rst_n  = 1'b0;
    i_ib_stb = 1'b0;
    sync();
    chk("midrst_ack", {30'd0, o_ib_ack, o_db_ack}, 32'd0);
    chk("midrst_csb", {31'd0, o_sram_csb}, 32'd1);
    chk("midrst_ib_rdt", o_ib_rdt, 32'd0);
    sync();
    chk("midrst_ack2", {30'd0, o_ib_ack, o_db_ack}, 32'd0);
    i_rst_n = 1'b1;
    c = cyc;
    push_exp(P_IB, 32'hFFFF_FC13, 1'b1, c + 3);
    ib_xfer(32'hFFFF_FC13, 1);

    repeat (4) sync();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_wb_arbiter.md
# sram_wb_arbiter

Two-port Wishbone arbiter and sequencer for the 256x32 SRAM macro's RW port (port 0). Shares the macro between the CPU instruction bus (read-only) and data bus (read/write with byte selects), using round-robin arbitration on collision. Sits between the CPU bus splitter and the macro. Drives the macro's registered-input / negedge-access timing with fully registered controls, and returns captured read data with a Wishbone ack.

## Interface
Parameters:
- AW, 8, macro word-address width (RAM depth = 2**AW)
- DW, 32, data width; byte-select width = DW/8

Ports:
- i_clk  in  1  system clock; also drives macro clk0
- i_rst_n  in  1  synchronous, active-low reset
- i_ib_adr  in  32  ibus byte address; word index = [AW+1:2]
- i_ib_stb  in  1  ibus request (cyc/stb merged), held until ack
- o_ib_rdt  out  DW  ibus read data, valid while o_ib_ack=1
- o_ib_ack  out  1  ibus ack, one-cycle pulse
- i_db_adr  in  32  dbus byte address; word index = [AW+1:2]
- i_db_dat  in  DW  dbus write data
- i_db_sel  in  DW/8  dbus byte selects
- i_db_we  in  1  dbus write enable
- i_db_stb  in  1  dbus request, held until ack
- o_db_rdt  out  DW  dbus read data, valid while o_db_ack=1
- o_db_ack  out  1  dbus ack, one-cycle pulse
- o_sram_csb  out  1  macro csb0 (active low)
- o_sram_web  out  1  macro web0 (active low)
- o_sram_wmask  out  DW/8  macro wmask0
- o_sram_addr  out  AW  macro addr0
- o_sram_din  out  DW  macro din0
- i_sram_dout  in  DW  macro dout0

## Operation
- FSM states: IDLE, CMD, WAIT, ACK.
- IDLE: if any stb is high, select a requester and register the macro controls: csb=0, addr, web=!we, wmask=sel, din=dat. ibus always uses web=1 and wmask=0. Record grant and go to CMD.
- CMD: macro controls are visible for exactly one cycle; the macro captures them at the closing posedge. Register csb=1 and go to WAIT.
- WAIT: the macro performs its access on the negedge. At the closing posedge, register i_sram_dout into the rdt register of the granted port, set that port's ack, and go to ACK.
- ACK: ack=1 for one cycle, then return to IDLE. The ack is cleared by the registered update at the end of ACK.
- Arbitration: a 1-bit last_grant register.
  - Only one stb high: grant it.
  - Both high: grant the port not equal to last_grant.
  - last_grant updates on each grant and resets to IBUS, so dbus wins the first collision.
- Requests are sampled only in IDLE. A stb that rises during CMD, WAIT or ACK waits for IDLE.
- Address bits above [AW+1:2] are ignored (aliasing). Bits [1:0] are ignored.
- Writes follow the same sequence. In a write, rdt captures don't-care data that the requester must ignore. The write with sel=0 still completes and acks; memory is unchanged.
- o_ib_rdt and o_db_rdt hold their last captured value between acks.

## Timing
- Reset values: o_sram_csb=1, o_sram_web=1, o_sram_wmask=0, o_sram_addr=0, o_sram_din=0, both acks=0, both rdt=0, state=IDLE, last_grant=IBUS.
- Latency: stb first seen high in IDLE at cycle N gives ack in cycle N+3.
- Throughput: one access per 4 cycles. With both ports continuously requesting, the grants alternate.
- The macro's csb is low for exactly one cycle per access and is never low in two consecutive cycles.
- Read data is captured at the posedge ending WAIT. This is before the macro's post-edge dout invalidation.
- Reset asserted mid-transaction: the next edge forces the reset values, and no ack is issued. A write already captured by the macro may still complete at its negedge. This is accepted; the requester reissues.
- The ungranted port's stb has no effect until the current transaction returns to IDLE.

## Structure
- Package sram_arb_pkg holds:
  - the state enum (IDLE, CMD, WAIT, ACK)
  - the grant constants GNT_IB=0 and GNT_DB=1
  - default AW and DW localparams
- Sub-module sram_rr_arb2: a combinational 2-way round-robin pick.
  - Inputs: req[1:0], last_grant.
  - Outputs: gnt_valid, gnt_id.
  - The FSM, registers and datapath stay in the top module.

## Test plan
- Reset: hold i_rst_n=0 for 3 cycles with both stb high. Expect csb=1, acks=0, both rdt=0. The first grant goes to dbus after release.
- dbus write then read: write adr=0x10, dat=0xDEADBEEF, sel=0xF. Expect ack at N+3 and one csb-low cycle with addr=4. A read of 0x10 then returns 0xDEADBEEF.
- Byte mask: write 0x11223344 with sel=0x5 over 0xDEADBEEF. A read returns 0xDE22BE44.
- Collision: both stb high with ibus adr=0x10, dbus read adr=0x14. Expect dbus ack at N+3 and ibus ack at N+7. ibus gets correct data. csb is never low in consecutive cycles.
- Fairness: both ports request continuously for 8 transactions. Grants alternate DB, IB, DB, IB and so on. Each port gets 4 acks.
- Reset mid-read: assert reset during WAIT. Expect no ack, and state IDLE after release. A reissued read returns correct data.
